full_subtractor_core: RTL and testbench

Registered, width-parameterised full subtractor (A − B − borrow-in) built from a ripple chain of 1-bit full-subtractor cells. It produces a difference and a borrow-out one clock after a qualified input. It is a leaf arithmetic block for datapaths that need borrow-chained subtraction, and it can be cascaded by feeding Co into the next instance's Ci.

---
 rtl/full_subtractor_core.sv | 103 ++++++++++
 tb/tb_full_subtractor_core.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_subtractor_core.sv
// Registered ripple-borrow full subtractor: D = A - B - Ci, Co = borrow-out.
// Optional registered Z/V flags when FULL_SUBTRACTOR_FLAGS_EN is defined.

module full_subtractor_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);

   logic w_axb;

   assign w_axb  = i_a ^ i_b;
   assign o_d    = w_axb ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);

endmodule

module full_subtractor_core #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Ci,
   output logic             out_valid,
   output logic [WIDTH-1:0] D,
`ifdef FULL_SUBTRACTOR_FLAGS_EN
   output logic             Co,
   output logic             Z,
   output logic             V
`else
   output logic             Co
`endif
);

   logic [WIDTH:0]   w_bin;
   logic [WIDTH-1:0] w_d;

   logic             r_valid;
   logic [WIDTH-1:0] r_d;
   logic             r_co;

   assign w_bin[0] = Ci;

   // Combinational ripple chain; only the output stage is registered.
   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      full_subtractor_cell u_cell (
         .i_a    (A[g]),
         .i_b    (B[g]),
         .i_bin  (w_bin[g]),
         .o_d    (w_d[g]),
         .o_bout (w_bin[g+1])
      );
   end

   // Operands are only sampled under in_valid, so idle X never loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_d     <= '0;
         r_co    <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_d  <= w_d;
            r_co <= w_bin[WIDTH];
         end
      end
   end

   assign out_valid = r_valid;
   assign D         = r_d;
   assign Co        = r_co;

`ifdef FULL_SUBTRACTOR_FLAGS_EN
   logic w_z;
   logic w_v;
   logic r_z;
   logic r_v;

   assign w_z = (w_d == '0);
   assign w_v = (A[WIDTH-1] != B[WIDTH-1]) &
                (w_d[WIDTH-1] != A[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_z <= 1'b0;
         r_v <= 1'b0;
      end else if (in_valid) begin
         r_z <= w_z;
         r_v <= w_v;
      end
   end

   assign Z = r_z;
   assign V = r_v;
`endif

endmodule

// File: tb/tb_full_subtractor_core.sv
// Self-checking bench for full_subtractor_core: arithmetic reference model
// compared every cycle, plus directed literal checks.

module tb_full_subtractor_core;

   typedef struct packed {
      logic        co;
      logic        z;
      logic        v;
      logic [63:0] d;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   logic       v1 = 0, a1 = 0, b1 = 0, c1 = 0;
   logic       v4 = 0, c4 = 0;
   logic [3:0] a4 = 0, b4 = 0;
   logic       v8 = 0, c8 = 0;
   logic [7:0] a8 = 0, b8 = 0;
   logic       vl = 0, cl = 0;
   logic [3:0] al = 0, bl = 0;
   logic       vh = 0, ch = 0;
   logic [3:0] ah = 0, bh = 0;

   logic       o1v, o1d, o1c;
   logic       o4v, o4c;
   logic [3:0] o4d;
   logic       o8v, o8c;
   logic [7:0] o8d;
   logic       olv, olc;
   logic [3:0] old;
   logic       ohv, ohc;
   logic [3:0] ohd;

`ifdef FULL_SUBTRACTOR_FLAGS_EN
   logic z1, f1, z4, f4, z8, f8, zl, fl, zh, fh;
`endif

   full_subtractor_core #(.WIDTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1),
      .A(a1), .B(b1), .Ci(c1),
      .out_valid(o1v), .D(o1d),
`ifdef FULL_SUBTRACTOR_FLAGS_EN
      .Co(o1c), .Z(z1), .V(f1)
`else
      .Co(o1c)
`endif
   );

   full_subtractor_core #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4),
      .A(a4), .B(b4), .Ci(c4),
      .out_valid(o4v), .D(o4d),
`ifdef FULL_SUBTRACTOR_FLAGS_EN
      .Co(o4c), .Z(z4), .V(f4)
`else
      .Co(o4c)
`endif
   );

   full_subtractor_core #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8),
      .A(a8), .B(b8), .Ci(c8),
      .out_valid(o8v), .D(o8d),
`ifdef FULL_SUBTRACTOR_FLAGS_EN
      .Co(o8c), .Z(z8), .V(f8)
`else
      .Co(o8c)
`endif
   );

   full_subtractor_core #(.WIDTH(4)) ulo (
      .clk(clk), .rst_n(rst_n), .in_valid(vl),
      .A(al), .B(bl), .Ci(cl),
      .out_valid(olv), .D(old),
`ifdef FULL_SUBTRACTOR_FLAGS_EN
      .Co(olc), .Z(zl), .V(fl)
`else
      .Co(olc)
`endif
   );

   full_subtractor_core #(.WIDTH(4)) uhi (
      .clk(clk), .rst_n(rst_n), .in_valid(vh),
      .A(ah), .B(bh), .Ci(ch),
      .out_valid(ohv), .D(ohd),
`ifdef FULL_SUBTRACTOR_FLAGS_EN
      .Co(ohc), .Z(zh), .V(fh)
`else
      .Co(ohc)
`endif
   );

   function automatic res_t ref_sub(int w, logic [63:0] a,
                                    logic [63:0] b, logic ci);
      logic [63:0] mask;
      logic [64:0] full;
      res_t r;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      a = a & mask;
      b = b & mask;
      full = {1'b0, a} - {1'b0, b} - 65'(ci);
      r.d  = full[63:0] & mask;
      r.co = ({1'b0, a} < ({1'b0, b} + 65'(ci)));
      r.z  = (r.d == 64'd0);
      r.v  = (a[w-1] != b[w-1]) && (r.d[w-1] != a[w-1]);
      return r;
   endfunction

   // Reference model: result registers and valid per instance.
   res_t m1, m4, m8, ml, mh;
   logic mv1, mv4, mv8, mvl, mvh;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1 <= '0; m4 <= '0; m8 <= '0; ml <= '0; mh <= '0;
         mv1 <= 0; mv4 <= 0; mv8 <= 0; mvl <= 0; mvh <= 0;
      end else begin
         mv1 <= v1; mv4 <= v4; mv8 <= v8; mvl <= vl; mvh <= vh;
         if (v1) m1 <= ref_sub(1, 64'(a1), 64'(b1), c1);
         if (v4) m4 <= ref_sub(4, 64'(a4), 64'(b4), c4);
         if (v8) m8 <= ref_sub(8, 64'(a8), 64'(b8), c8);
         if (vl) ml <= ref_sub(4, 64'(al), 64'(bl), cl);
         if (vh) mh <= ref_sub(4, 64'(ah), 64'(bh), ch);
      end
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cmp(string n, logic av, logic [63:0] ad, logic ac,
                      logic ev, res_t e);
      chk({n, ".valid"}, 64'(av), 64'(ev));
      chk({n, ".D"}, ad, e.d);
      chk({n, ".Co"}, 64'(ac), 64'(e.co));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("u1", o1v, 64'(o1d), o1c, mv1, m1);
         cmp("u4", o4v, 64'(o4d), o4c, mv4, m4);
         cmp("u8", o8v, 64'(o8d), o8c, mv8, m8);
         cmp("ulo", olv, 64'(old), olc, mvl, ml);
         cmp("uhi", ohv, 64'(ohd), ohc, mvh, mh);
`ifdef FULL_SUBTRACTOR_FLAGS_EN
         chk("u8.Z", 64'(z8), 64'(m8.z));
         chk("u8.V", 64'(f8), 64'(m8.v));
         chk("u4.Z", 64'(z4), 64'(m4.z));
         chk("u4.V", 64'(f4), 64'(m4.v));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] w1_in [6];
   logic [1:0] w1_out [6];

   initial begin
      w1_in[0] = 3'b000; w1_out[0] = 2'b00;
      w1_in[1] = 3'b100; w1_out[1] = 2'b10;
      w1_in[2] = 3'b110; w1_out[2] = 2'b00;
      w1_in[3] = 3'b111; w1_out[3] = 2'b11;
      w1_in[4] = 3'b011; w1_out[4] = 2'b01;
      w1_in[5] = 3'b001; w1_out[5] = 2'b11;

      tick();
      chk("rst.u8.D", 64'(o8d), 64'h0);
      chk("rst.u8.Co", 64'(o8c), 64'h0);
      chk("rst.u8.valid", 64'(o8v), 64'h0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // WIDTH=1 truth sequence, back-to-back
      for (int i = 0; i < 6; i++) begin
         v1 = 1'b1;
         {a1, b1, c1} = w1_in[i];
         tick();
         chk($sformatf("w1.v%0d.DCo", i), 64'({o1d, o1c}),
             64'(w1_out[i]));
         chk($sformatf("w1.v%0d.valid", i), 64'(o1v), 64'h1);
      end
      v1 = 1'b0;

      // WIDTH=8 directed
      v8 = 1; a8 = 8'h00; b8 = 8'h01; c8 = 0;
      tick();
      chk("w8.0-1.D", 64'(o8d), 64'hFF);
      chk("w8.0-1.Co", 64'(o8c), 64'h1);
      a8 = 8'h80; b8 = 8'h01; c8 = 0;
      tick();
      chk("w8.80-1.D", 64'(o8d), 64'h7F);
      chk("w8.80-1.Co", 64'(o8c), 64'h0);
`ifdef FULL_SUBTRACTOR_FLAGS_EN
      chk("w8.80-1.V", 64'(f8), 64'h1);
`endif
      a8 = 8'h05; b8 = 8'h04; c8 = 1;
      tick();
      chk("w8.5-4-1.D", 64'(o8d), 64'h00);
      chk("w8.5-4-1.Co", 64'(o8c), 64'h0);
`ifdef FULL_SUBTRACTOR_FLAGS_EN
      chk("w8.5-4-1.Z", 64'(z8), 64'h1);
`endif

      // Hold with idle garbage / X on operands
      a8 = 8'h10; b8 = 8'h03; c8 = 0;
      tick();
      chk("hold.load.D", 64'(o8d), 64'h0D);
      v8 = 0;
      for (int i = 0; i < 3; i++) begin
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         c8 = 1'($urandom);
         if (i == 1) begin
            a8 = 'x; b8 = 'x; c8 = 'x;
         end
         tick();
         chk($sformatf("hold%0d.D", i), 64'(o8d), 64'h0D);
         chk($sformatf("hold%0d.Co", i), 64'(o8c), 64'h0);
         chk($sformatf("hold%0d.valid", i), 64'(o8v), 64'h0);
      end

      // Async reset between edges during back-to-back ops
      v8 = 1; a8 = 8'h42; b8 = 8'h11; c8 = 0;
      tick();
      a8 = 8'h01; b8 = 8'h02; c8 = 1;
      tick();
      chk("pre_rst.D", 64'(o8d), 64'hFE);
      chk("pre_rst.Co", 64'(o8c), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst.D", 64'(o8d), 64'h0);
      chk("async_rst.Co", 64'(o8c), 64'h0);
      chk("async_rst.valid", 64'(o8v), 64'h0);
      v8 = 0;
      tick();
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst.idle.valid", 64'(o8v), 64'h0);
      v8 = 1; a8 = 8'h09; b8 = 8'h03; c8 = 0;
      tick();
      chk("post_rst.first.valid", 64'(o8v), 64'h1);
      chk("post_rst.first.D", 64'(o8d), 64'h06);
      v8 = 0;

      // Exhaustive WIDTH=4 through the every-cycle compare
      for (int i = 0; i < 512; i++) begin
         v4 = 1;
         a4 = 4'(i >> 5);
         b4 = 4'(i >> 1);
         c4 = 1'(i);
         tick();
      end
      v4 = 0;

      // Cascade two WIDTH=4 against a WIDTH=8
      vl = 1; al = 4'h0; bl = 4'hF; cl = 0;
      v8 = 1; a8 = 8'h30; b8 = 8'h0F; c8 = 0;
      tick();
      vl = 0; v8 = 0;
      vh = 1; ah = 4'h3; bh = 4'h0; ch = olc;
      tick();
      vh = 0;
      chk("casc.D", 64'({ohd, old}), 64'h21);
      chk("casc.Co", 64'(ohc), 64'h0);
      chk("casc.vs_w8.D", 64'({ohd, old}), 64'(o8d));
      chk("casc.vs_w8.Co", 64'(ohc), 64'(o8c));

      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
